// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers and a shift window.
// Optional start-of-frame resync input sof_i is compiled in with `define SOBEL_WIN_SOF_EN.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_i,
    input  logic       pixel_valid_i,
`ifdef SOBEL_WIN_SOF_EN
    input  logic       sof_i,
`endif
    output logic [7:0] d0_o,
    output logic [7:0] d1_o,
    output logic [7:0] d2_o,
    output logic [7:0] d3_o,
    output logic [7:0] d4_o,
    output logic [7:0] d5_o,
    output logic [7:0] d6_o,
    output logic [7:0] d7_o,
    output logic [7:0] d8_o,
    output logic       done_o,
    output logic       frame_done_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col, eff_col;
    logic [RW-1:0] row, eff_row;
    logic          accept, col_last, row_last, in_window;

    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] win [9];

    // Position of the pixel being accepted this cycle; sof_i overrides it to the frame origin.
    always_comb begin
        eff_col = col;
        eff_row = row;
`ifdef SOBEL_WIN_SOF_EN
        if (sof_i) begin
            eff_col = '0;
            eff_row = '0;
        end
`endif
    end

    assign accept    = pixel_valid_i;
    assign col_last  = (eff_col == COL_LAST);
    assign row_last  = (eff_row == ROW_LAST);
    assign in_window = (eff_row >= RW'(2)) && (eff_col >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end
    end

    // NOTE: line-buffer RAM is deliberately not reset so it maps to block RAM; rows 0 and 1
    // never emit, so stale contents can never reach the outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[eff_col] <= lb1[eff_col];
            lb1[eff_col] <= pixel_i;
        end
    end

    // NOTE: non-blocking reads below see the pre-write line-buffer contents, giving
    // read-before-write behaviour at the same column in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else if (accept) begin
            for (int k = 0; k < 3; k++) begin
                win[3*k]   <= win[3*k+1];
                win[3*k+1] <= win[3*k+2];
            end
            win[2] <= lb0[eff_col];
            win[5] <= lb1[eff_col];
            win[8] <= pixel_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            done_o       <= accept && in_window;
            frame_done_o <= accept && row_last && col_last;
        end
    end

    assign d0_o = win[0];
    assign d1_o = win[1];
    assign d2_o = win[2];
    assign d3_o = win[3];
    assign d4_o = win[4];
    assign d5_o = win[5];
    assign d6_o = win[6];
    assign d7_o = win[7];
    assign d8_o = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x4 image; sof_i scenario runs under SOBEL_WIN_SOF_EN.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    typedef logic [71:0] win_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pixel = '0;
    logic       valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic       done, frame_done;

    win_t sb[$];
    win_t got, exp_w, first_win, last_win;
    int   mr = 0, mc = 0;
    int   win_count = 0, fd_count = 0;
    int   n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pixel_i(pixel), .pixel_valid_i(valid),
`ifdef SOBEL_WIN_SOF_EN
        .sof_i(sof),
`endif
        .d0_o(d0), .d1_o(d1), .d2_o(d2), .d3_o(d3), .d4_o(d4), .d5_o(d5), .d6_o(d6),
        .d7_o(d7), .d8_o(d8), .done_o(done), .frame_done_o(frame_done)
    );

    function automatic win_t exp_win(input logic [7:0] base, input int r, input int c);
        win_t w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[71-8*(3*i+j) -: 8] = base + 8'(16*(r-2+i) + (c-2+j));
        return w;
    endfunction

    // Accept one pixel of the frame with the given base value and score the DUT response.
    task automatic run_pixel(input logic [7:0] base, input logic s, input string tag);
        logic ed, efd;
        if (s) begin mr = 0; mc = 0; end
        ed  = (mr >= 2) && (mc >= 2);
        efd = (mr == H-1) && (mc == W-1);
        if (ed) sb.push_back(exp_win(base, mr, mc));
        @(negedge clk);
        pixel = base + 8'(16*mr + mc);
        valid = 1'b1;
        sof   = s;
        @(posedge clk); #1;
        valid = 1'b0;
        sof   = 1'b0;
        if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
        else mc = mc + 1;
        n_checks++;
        if (done !== ed) $display("FAIL %s done r%0d: got %b want %b", tag, mr, done, ed);
        else n_pass++;
        n_checks++;
        if (frame_done !== efd) $display("FAIL %s frame_done: got %b want %b", tag, frame_done, efd);
        else n_pass++;
        if (frame_done === 1'b1) fd_count++;
        if (done === 1'b1) begin
            got = {d0, d1, d2, d3, d4, d5, d6, d7, d8};
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL %s unexpected window: got %h want none", tag, got);
            end else begin
                exp_w = sb.pop_front();
                if (got !== exp_w) $display("FAIL %s window: got %h want %h", tag, got, exp_w);
                else n_pass++;
            end
            if (win_count == 0) first_win = got;
            last_win = got;
            win_count++;
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || frame_done !== 1'b0)
                $display("FAIL %s stall strobe: got done=%b fd=%b want 0 0", tag, done, frame_done);
            else n_pass++;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        pixel = 8'hEE;
        @(posedge clk); #1;
        n_checks++;
        if ({d0, d1, d2, d3, d4, d5, d6, d7, d8, done, frame_done} !== '0)
            $display("FAIL %s outputs: got %h done=%b fd=%b want 0", tag,
                     {d0, d1, d2, d3, d4, d5, d6, d7, d8}, done, frame_done);
        else n_pass++;
        rst   = 1'b0;
        valid = 1'b0;
        mr = 0; mc = 0;
        sb.delete();
    endtask

    task automatic stream_frame(input logic [7:0] base, input int max_gap, input logic sof_first,
                                input string tag);
        win_count = 0;
        fd_count  = 0;
        for (int i = 0; i < W*H; i++) begin
            run_pixel(base, sof_first && (i == 0), tag);
            if (max_gap > 0) idle($urandom_range(max_gap, 1), tag);
        end
        n_checks++;
        if (win_count !== 4 || sb.size() != 0)
            $display("FAIL %s window count: got %0d (left %0d) want 4", tag, win_count, sb.size());
        else n_pass++;
        n_checks++;
        if (fd_count !== 1) $display("FAIL %s frame_done count: got %0d want 1", tag, fd_count);
        else n_pass++;
    endtask

    task automatic check_first_last(input string tag);
        n_checks++;
        if (first_win !== 72'h000102101112202122)
            $display("FAIL %s first window: got %h want 000102101112202122", tag, first_win);
        else n_pass++;
        n_checks++;
        if (last_win !== 72'h111213212223313233)
            $display("FAIL %s last window: got %h want 111213212223313233", tag, last_win);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_basic();
        stream_frame(8'h00, 0, 1'b0, "basic");
        check_first_last("basic");
    endtask

    task automatic test_stall();
        do_reset("stall_rst");
        stream_frame(8'h00, 3, 1'b0, "stall");
        check_first_last("stall");
    endtask

    task automatic test_back_to_back();
        do_reset("b2b_rst");
        stream_frame(8'h00, 0, 1'b0, "b2b_f1");
        stream_frame(8'h80, 0, 1'b0, "b2b_f2");
        n_checks++;
        if (first_win !== 72'h808182909192A0A1A2)
            $display("FAIL b2b_f2 first window: got %h want 808182909192a0a1a2", first_win);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset("mid_rst0");
        for (int i = 0; i < 2*W + 2; i++) run_pixel(8'h40, 1'b0, "mid_pre");
        do_reset("mid_rst");
        stream_frame(8'h00, 0, 1'b0, "mid");
        check_first_last("mid");
    endtask

    task automatic test_line_wrap();
        do_reset("wrap_rst");
        for (int i = 0; i < 3*W; i++) run_pixel(8'h00, 1'b0, "wrap_pre");
        for (int c = 0; c < 2; c++) begin
            run_pixel(8'h00, 1'b0, "wrap");
            n_checks++;
            if (done !== 1'b0) $display("FAIL wrap col%0d done: got %b want 0", c, done);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) run_pixel(8'h00, 1'b0, "wrap_post");
        n_checks++;
        if (sb.size() != 0) $display("FAIL wrap leftover windows: got %0d want 0", sb.size());
        else n_pass++;
    endtask

`ifdef SOBEL_WIN_SOF_EN
    task automatic test_sof();
        do_reset("sof_rst");
        for (int i = 0; i < 5; i++) run_pixel(8'h55, 1'b0, "sof_junk");
        stream_frame(8'h00, 0, 1'b1, "sof");
        check_first_last("sof");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_line_wrap();
`ifdef SOBEL_WIN_SOF_EN
        test_sof();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
